// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: default widths, ALU opcodes
// and the arbiter FSM state encoding.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_OP_W   = 3;

    // Opcodes understood by the combinational ALU
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_NEG   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_PASSA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two ALU requesters, the ALU and the response consumer.
// Ports:
//   req0_*/req1_* : valid/ready request channels (op, a, b)
//   alu_*         : operands out to the ALU, result and Z/N flags back
//   rsp_*         : valid/ready response channel (id, data, z, n, err)
// Modports: master = environment (requesters, ALU, consumer), slave = arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W
);

    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z;
    logic              alu_n;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_z;
    logic              rsp_n;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_out, alu_z, alu_n,
        input  rsp_valid, rsp_id, rsp_data, rsp_z, rsp_n, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_out, alu_z, alu_n,
        output rsp_valid, rsp_id, rsp_data, rsp_z, rsp_n, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_arbiter_arb.sv
// Combinational 2-way round-robin picker.
// Ports:
//   valid[1:0]  : request valids
//   last_grant  : index of the previous winner (loses a tie)
//   grant[1:0]  : one-hot grant, zero when nothing is valid
//   winner      : index of the granted requester (0 when nothing is valid)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
        if (|valid) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the PC/branch path (requester 0) and the
// execute stage (requester 1). Round-robin arbitration, registered operands,
// captured result/flags returned with the requester id over valid/ready.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_arbiter_if.slave (request, ALU and response channels)
//   stat_cnt0/stat_cnt1/stat_err_cnt : response statistics, present only when
//              ALU_ARB_STATS_EN is defined
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]   stat_cnt0,
    output logic [15:0]   stat_cnt1,
    output logic [7:0]    stat_err_cnt
`endif
);

    state_t            state, state_nxt;
    logic              last_grant;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              err_q;

    logic              rsp_valid_q, rsp_id_q, rsp_z_q, rsp_n_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [1:0]        grant;
    logic              winner;
    logic              accept_c, capture_c, handshake_c;
    logic              ready0_c, ready1_c;

    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_legal;

    rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .winner     (winner)
    );

    // Winner's request and its opcode legality
    always_comb begin
        sel_op    = winner ? bus.req1_op : bus.req0_op;
        sel_a     = winner ? bus.req1_a  : bus.req0_a;
        sel_b     = winner ? bus.req1_b  : bus.req0_b;
        sel_legal = (sel_op == OP_W'(OP_ADD)) || (sel_op == OP_W'(OP_NEG)) ||
                    (sel_op == OP_W'(OP_SUB)) || (sel_op == OP_W'(OP_PASSA));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and strobes; ready is only ever offered in IDLE
    always_comb begin
        state_nxt   = state;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        handshake_c = 1'b0;
        ready0_c    = 1'b0;
        ready1_c    = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept_c  = 1'b1;
                    ready0_c  = grant[0];
                    ready1_c  = grant[1];
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture_c = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    handshake_c = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= 1'b1;
            op_q        <= OP_W'(OP_PASSA);
            a_q         <= '0;
            b_q         <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                last_grant <= winner;
                rsp_id_q   <= winner;
                a_q        <= sel_a;
                b_q        <= sel_b;
                // Illegal opcodes run as a harmless pass-A and are flagged
                op_q       <= sel_legal ? sel_op : OP_W'(OP_PASSA);
                err_q      <= ~sel_legal;
            end
            if (capture_c) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_q;
                rsp_data_q  <= err_q ? '0 : bus.alu_out;
                rsp_z_q     <= err_q ? 1'b0 : bus.alu_z;
                rsp_n_q     <= err_q ? 1'b0 : bus.alu_n;
            end
            if (handshake_c) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester response counters (wrapping) and illegal-op counter (saturating)
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt0    <= 16'd0;
            stat_cnt1    <= 16'd0;
            stat_err_cnt <= 8'd0;
        end else if (handshake_c) begin
            if (rsp_id_q) begin
                stat_cnt1 <= stat_cnt1 + 16'd1;
            end else begin
                stat_cnt0 <= stat_cnt0 + 16'd1;
            end
            if (rsp_err_q && (stat_err_cnt != 8'hFF)) begin
                stat_err_cnt <= stat_err_cnt + 8'd1;
            end
        end
    end
`endif

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_n      = rsp_n_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of single-requester operations, back-pressure,
// reset during EXEC and a both-requesters round-robin sequence. Responses are
// matched against a queue of expectations pushed at each accept.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        int          req;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        z;
        logic        n;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    alu_arbiter_if #(.DATA_W(32), .OP_W(3)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1;
    logic [7:0]  stat_err_cnt;
`endif

    alu_arbiter #(.DATA_W(32), .OP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_cnt0    (stat_cnt0),
        .stat_cnt1    (stat_cnt1),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the combinational ALU
    logic [31:0] alu_res;
    always_comb begin
        case (bus.alu_op)
            3'b100:  alu_res = bus.alu_a + bus.alu_b;
            3'b010:  alu_res = 32'd0 - bus.alu_b;
            3'b001:  alu_res = bus.alu_a - bus.alu_b;
            default: alu_res = bus.alu_a;
        endcase
        bus.alu_out = alu_res;
        bus.alu_z   = (alu_res == 32'd0);
        bus.alu_n   = alu_res[31];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    vec_t exp_cur [2];
    vec_t sb [$];
    int   acc [$];
    int   ids_seen [$];
    logic prev_rv = 1'b0;

    // Monitor: accepts push expectations, handshakes pop and compare
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            acc.delete();
            prev_rv = 1'b0;
        end else begin
            check("ready_both", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            check("ready_in_resp", 32'(bus.rsp_valid & (bus.req0_ready | bus.req1_ready)), 32'd0);
            check("ready_without_valid",
                  32'((bus.req0_ready & ~bus.req0_valid) | (bus.req1_ready & ~bus.req1_valid)), 32'd0);
            if (bus.req0_ready) begin
                sb.push_back(exp_cur[0]);
                acc.push_back(cyc);
            end
            if (bus.req1_ready) begin
                sb.push_back(exp_cur[1]);
                acc.push_back(cyc);
            end
            if (bus.rsp_valid && !prev_rv) begin
                if (acc.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_valid_without_accept actual=1 required=0");
                end else begin
                    int a;
                    a = acc.pop_front();
                    check("latency", 32'(cyc - a), 32'd2);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                ids_seen.push_back(int'(bus.rsp_id));
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=id%0d required=none", bus.rsp_id);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    check("rsp_id",   32'(bus.rsp_id), 32'(e.req));
                    check("rsp_data", bus.rsp_data,    e.data);
                    check("rsp_z",    32'(bus.rsp_z),  32'(e.z));
                    check("rsp_n",    32'(bus.rsp_n),  32'(e.n));
                    check("rsp_err",  32'(bus.rsp_err), 32'(e.err));
                end
            end
            prev_rv = bus.rsp_valid;
        end
    end

    // Present one request until accepted, then drop valid
    task automatic issue(input vec_t v);
        bit done;
        done = 1'b0;
        exp_cur[v.req] = v;
        if (v.req == 0) begin
            bus.req0_op = v.op; bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = v.op; bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((v.req == 0 && bus.req0_ready) || (v.req == 1 && bus.req1_ready)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_ready required=ready req=%0d", v.req);
        end
        @(posedge clk);
        #1;
        if (v.req == 0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
    endtask

    // Wait until nothing is pending anywhere
    task automatic wait_drain();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (!bus.req0_valid && !bus.req1_valid && sb.size() == 0 && !bus.rsp_valid) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=pending%0d required=0", sb.size());
        end
    endtask

    vec_t vecs [11];
    vec_t bv [4];
    int   exp_ids [4];

    initial begin
        int n0, n1, nerr;
        vecs[0]  = '{0, 3'b100, 32'd5,          32'd7,          32'h0000000C, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1, 3'b001, 32'd3,          32'd5,          32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1, 3'b001, 32'd9,          32'd9,          32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 3'b011, 32'd1,          32'd2,          32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{0, 3'b010, 32'd0,          32'd1,          32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1, 3'b111, 32'h80000000,   32'h12345678,   32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{0, 3'b100, 32'hFFFFFFFF,   32'd1,          32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1, 3'b101, 32'd7,          32'd7,          32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{0, 3'b000, 32'd0,          32'd0,          32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1, 3'b110, 32'h0000AAAA,   32'h00005555,   32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{0, 3'b001, 32'd0,          32'h80000000,   32'h80000000, 1'b0, 1'b1, 1'b0};

        bv[0] = '{0, 3'b100, 32'd1,  32'd2, 32'h00000003, 1'b0, 1'b0, 1'b0};
        bv[1] = '{1, 3'b001, 32'd10, 32'd3, 32'h00000007, 1'b0, 1'b0, 1'b0};
        bv[2] = '{0, 3'b111, 32'd4,  32'd9, 32'h00000004, 1'b0, 1'b0, 1'b0};
        bv[3] = '{1, 3'b010, 32'd0,  32'd5, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0};
        exp_ids = '{0, 1, 0, 1};

        bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp_ready  = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_op",    32'(bus.alu_op),    32'h7);
        check("rst_alu_a",     bus.alu_a,          32'd0);
        check("rst_alu_b",     bus.alu_b,          32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_ready",     32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-requester table
        n0 = 0; n1 = 0; nerr = 0;
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i]);
            wait_drain();
            if (vecs[i].req == 0) n0++; else n1++;
            if (vecs[i].err) nerr++;
        end
`ifdef ALU_ARB_STATS_EN
        check("stat_cnt0",    32'(stat_cnt0),    32'(n0));
        check("stat_cnt1",    32'(stat_cnt1),    32'(n1));
        check("stat_err_cnt", 32'(stat_err_cnt), 32'(nerr));
`endif

        // Response back-pressure with a competing request pending
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        issue('{0, 3'b100, 32'h10, 32'h20, 32'h00000030, 1'b0, 1'b0, 1'b0});
        fork
            issue('{1, 3'b001, 32'h30, 32'h10, 32'h00000020, 1'b0, 1'b0, 1'b0});
        join_none
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_data",  bus.rsp_data,       32'h00000030);
            check("hold_rsp_id",    32'(bus.rsp_id),    32'd0);
            check("hold_req1_ready", 32'(bus.req1_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        wait_drain();

        // Reset while in EXEC abandons the operation
        @(posedge clk);
        #1;
        issue('{0, 3'b100, 32'd1, 32'd1, 32'h00000002, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("exec_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("exec_rst_alu_op",    32'(bus.alu_op),    32'h7);
`ifdef ALU_ARB_STATS_EN
        check("exec_rst_stat_cnt0",    32'(stat_cnt0),    32'd0);
        check("exec_rst_stat_cnt1",    32'(stat_cnt1),    32'd0);
        check("exec_rst_stat_err_cnt", 32'(stat_err_cnt), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("exec_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Both requesters continuously valid: round-robin from reset
        @(posedge clk);
        #1;
        ids_seen.delete();
        fork
            begin issue(bv[0]); issue(bv[2]); end
            begin issue(bv[1]); issue(bv[3]); end
        join
        wait_drain();
        check("rr_count", 32'(ids_seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ids_seen.size()) check("rr_id_order", 32'(ids_seen[i]), 32'(exp_ids[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
